switch_conditioner: RTL and testbench
=====================================

// Module: switch_conditioner
// PURPOSE
//   Front-end conditioner between raw board switches and the coffee-machine controller.
//   Synchronises and debounces each switch, then emits one-cycle press/release pulses.
//   Encodes release events into a single prioritised command (cmd_valid/cmd_id),
//   because the controller acts on switch release.
// PARAMETERS
//   N          5   number of conditioned switches (SW[N-1:0])
//   DEBOUNCE   4   consecutive stable cycles required to accept a level change
//                  (>=1; 500000 = 10 ms @ 50 MHz on board)
//   CNT_W      20  debounce counter width; must hold DEBOUNCE-1
//   ID_W       3   cmd_id width; must be >= clog2(N)
// PORTS
//   CLOCK_50       in   1     system clock, all logic on rising edge
//   RESET_N        in   1     asynchronous, active-low reset
//   sw_in          in   N     raw switch levels, asynchronous to CLOCK_50
//   sw_level       out  N     debounced switch levels
//   press_pulse    out  N     1-cycle pulse per bit on debounced 0->1
//   release_pulse  out  N     1-cycle pulse per bit on debounced 1->0
//   cmd_valid      out  1     1 when any release_pulse bit is 1
//   cmd_id         out  ID_W  index of highest-numbered releasing bit; 0 when !cmd_valid
//   cmd_collision  out  1     1 when more than one release_pulse bit is 1 in the same cycle
// BEHAVIOUR
//   Reset
//   - RESET_N low clears all flops immediately: sync stages, debounce counters,
//     sw_level, pulses, cmd_*.
//   - Every output reads 0 during reset and in the first cycle after release.
//   Per-bit pipeline
//   - Two-flop synchroniser sw_in -> s1 -> s2.
//   - Each rising edge, when s2 != sw_level:
//     - cnt == DEBOUNCE-1: sw_level <= s2, cnt <= 0.
//     - otherwise: cnt <= cnt+1.
//   - Each rising edge, when s2 == sw_level: cnt <= 0. Any bounce restarts the count.
//   - Latency: input steady from sampling edge k -> sw_level updates at edge k+1+DEBOUNCE.
//   - Pulses shorter than DEBOUNCE cycles at s2 never reach sw_level.
//   Pulses
//   - Registered on the same edge that sw_level changes.
//   - press_pulse[i] = 1 in exactly the first cycle sw_level[i] is 1.
//   - release_pulse[i] = 1 in exactly the first cycle sw_level[i] is 0.
//   - One pulse per accepted transition.
//   - press and release never both 1 for a bit in the same cycle.
//   Command encoder
//   - Combinational from registered release_pulse.
//   - Priority is highest index: SW4 return > SW3 buy > SW2 1000 > SW1 500 > SW0 100.
//   - Lower-priority simultaneous releases still appear in release_pulse.
//   - On a simultaneous release, cmd_collision = 1 for that cycle only.
//   Boundaries
//   - Switch held high across reset deassert: after deassert it is treated as a new
//     press (press_pulse after DEBOUNCE+2 cycles).
//   - Reset mid-count: count discarded; no pulse from the pre-reset activity.
//   - Counter never wraps; it saturates by construction at DEBOUNCE-1.
//   - Independent bits debounce concurrently with no interaction.
// TESTING  (N=5, DEBOUNCE=4, 20 ns clock)
//   1 RESET_N=0 with sw_in=5'h1F -> all outputs 0; after release,
//     sw_level=5'h1F and press_pulse=5'h1F at edge 6, each 1 cycle.
//   2 sw_in[2]=1 for 5 cycles, then 0:
//     - press_pulse[2] once, 6 edges after rise.
//     - release_pulse[2] once, 6 edges after fall.
//     - cmd_valid=1 with cmd_id=2 for 1 cycle.
//   3 sw_in[0]=1 for 2 cycles only -> sw_level[0] stays 0; no pulses; cmd_valid stays 0.
//   4 sw_in[1] toggles 1,0,1,0,1 per cycle, then held 1 ->
//     exactly one press_pulse[1], 6 edges after the last 0->1.
//   5 sw_in[3] and sw_in[4] held 1, then dropped together ->
//     release_pulse=5'b11000, cmd_id=4, cmd_collision=1, all for 1 cycle.
//   6 sw_in[1]=1 for 3 cycles, RESET_N pulsed low, input back to 0 ->
//     outputs 0 asynchronously; no pulse afterwards.

Source files
------------

// File: rtl/switch_conditioner_if.sv
// switch_conditioner_if: raw switch inputs plus conditioned levels, pulses and release command
interface switch_conditioner_if #(parameter int N = 5, parameter int ID_W = 3);
  logic [N-1:0] sw_in;
  logic [N-1:0] sw_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic cmd_valid;
  logic [ID_W-1:0] cmd_id;
  logic cmd_collision;
  modport master(output sw_in, input sw_level, press_pulse, release_pulse, cmd_valid, cmd_id, cmd_collision);
  modport slave(input sw_in, output sw_level, press_pulse, release_pulse, cmd_valid, cmd_id, cmd_collision);
endinterface

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronise, debounce and edge-detect board switches; encode releases into a command
module switch_conditioner #(
  parameter int N = 5,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W = 20,
  parameter int ID_W = 3
) (
  input logic CLOCK_50,
  input logic RESET_N,
  switch_conditioner_if.slave bus
);
  logic [N-1:0] s1, s2, level, press, rel;
  logic [CNT_W-1:0] cnt [N];
  logic [ID_W-1:0] id;
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      s1 <= '0;
      s2 <= '0;
      level <= '0;
      press <= '0;
      rel <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= bus.sw_in;
      s2 <= s1;
      for (int i = 0; i < N; i++) begin
        press[i] <= 1'b0;
        rel[i] <= 1'b0;
        if (s2[i] == level[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
          level[i] <= s2[i];
          cnt[i] <= '0;
          press[i] <= s2[i];
          rel[i] <= ~s2[i];
        end else cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  // later iterations overwrite earlier ones, so the highest releasing index wins
  always_comb begin
    id = '0;
    for (int i = 0; i < N; i++) if (rel[i]) id = ID_W'(i);
  end
  assign bus.sw_level = level;
  assign bus.press_pulse = press;
  assign bus.release_pulse = rel;
  assign bus.cmd_valid = |rel;
  assign bus.cmd_id = id;
  assign bus.cmd_collision = |(rel & (rel - N'(1)));
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed and random stimulus against a sliding-window reference model
module tb_switch_conditioner;
  localparam int N = 5;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #10 clk = ~clk;
  switch_conditioner_if #(.N(N), .ID_W(3)) bus();
  switch_conditioner #(.N(N), .DEBOUNCE(DB), .CNT_W(20), .ID_W(3)) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );
  // smp[0] is the input seen at this edge; the synchronised value used at this edge is smp[2].
  // A level flips once DB consecutive synchronised samples all disagree with it.
  logic [N-1:0] smp [$];
  logic [N-1:0] m_lev, m_prs, m_rel;
  logic flip;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp = {};
      repeat (DB + 2) smp.push_back('0);
      m_lev = '0;
      m_prs = '0;
      m_rel = '0;
    end else begin
      smp.push_front(bus.sw_in);
      smp = smp[0:DB+1];
      m_prs = '0;
      m_rel = '0;
      for (int i = 0; i < N; i++) begin
        flip = 1'b1;
        for (int k = 2; k < DB + 2; k++) if (smp[k][i] == m_lev[i]) flip = 1'b0;
        if (flip) begin
          m_lev[i] = ~m_lev[i];
          if (m_lev[i]) m_prs[i] = 1'b1;
          else m_rel[i] = 1'b1;
        end
      end
    end
  end
  logic [2:0] e_id;
  logic [19:0] exp_v, obs;
  always_comb begin
    e_id = '0;
    if (m_rel != '0) e_id = 3'($clog2(int'(m_rel) + 1) - 1);
    exp_v = {m_lev, m_prs, m_rel, m_rel != '0, e_id, $countones(m_rel) > 1};
  end
  assign obs = {bus.sw_level, bus.press_pulse, bus.release_pulse, bus.cmd_valid, bus.cmd_id, bus.cmd_collision};

  task automatic test_reset;
    rst_n = 1'b0;
    bus.sw_in = 5'h1F;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs !== 20'h0) begin fails++; $display("FAIL reset_hold got=%h want=0", obs); end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL reset_model edge=%0d got=%h want=%h", e, obs, exp_v); end
      tests++;
      if (bus.press_pulse !== (e == 6 ? 5'h1F : 5'h00) || bus.sw_level !== (e >= 6 ? 5'h1F : 5'h00)) begin
        fails++; $display("FAIL reset_press edge=%0d press=%h level=%h", e, bus.press_pulse, bus.sw_level);
      end
    end
    bus.sw_in = '0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL reset_drop edge=%0d got=%h want=%h", e, obs, exp_v); end
    end
  endtask

  task automatic test_press_release;
    int np = 0;
    int nr = 0;
    bus.sw_in = 5'b00100;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL pr_model edge=%0d got=%h want=%h", e, obs, exp_v); end
      if (bus.press_pulse[2]) begin
        np++;
        tests++;
        if (e != 6) begin fails++; $display("FAIL pr_press_edge got=%0d want=6", e); end
      end
      if (bus.release_pulse[2]) begin
        nr++;
        tests++;
        if (e != 11 || bus.cmd_valid !== 1'b1 || bus.cmd_id !== 3'd2 || bus.cmd_collision !== 1'b0) begin
          fails++; $display("FAIL pr_release edge=%0d valid=%b id=%0d coll=%b want edge=11 1/2/0", e, bus.cmd_valid, bus.cmd_id, bus.cmd_collision);
        end
      end
      if (e == 5) bus.sw_in = '0;
    end
    tests++;
    if (np != 1 || nr != 1) begin fails++; $display("FAIL pr_counts press=%0d release=%0d want 1/1", np, nr); end
  endtask

  task automatic test_glitch;
    bus.sw_in = 5'b00001;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL glitch_model edge=%0d got=%h want=%h", e, obs, exp_v); end
      tests++;
      if ((bus.sw_level[0] | bus.press_pulse[0] | bus.release_pulse[0] | bus.cmd_valid) !== 1'b0) begin
        fails++; $display("FAIL glitch_leak edge=%0d got=%h want level0/pulses/valid=0", e, obs);
      end
      if (e == 2) bus.sw_in = '0;
    end
  endtask

  task automatic test_bounce;
    logic seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int np = 0;
    int pe = 0;
    bus.sw_in = {3'b000, seq[0], 1'b0};
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL bounce_model edge=%0d got=%h want=%h", e, obs, exp_v); end
      if (bus.press_pulse[1]) begin np++; pe = e; end
      if (e < 5) bus.sw_in[1] = seq[e];
    end
    tests++;
    if (np != 1 || pe != 10) begin fails++; $display("FAIL bounce_press count=%0d edge=%0d want 1 at 10", np, pe); end
    bus.sw_in = '0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL bounce_drop edge=%0d got=%h want=%h", e, obs, exp_v); end
    end
  endtask

  task automatic test_collision;
    bus.sw_in = 5'b11000;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL coll_model edge=%0d got=%h want=%h", e, obs, exp_v); end
      if (e == 16) begin
        tests++;
        if (bus.release_pulse !== 5'b11000 || bus.cmd_valid !== 1'b1 || bus.cmd_id !== 3'd4 || bus.cmd_collision !== 1'b1) begin
          fails++; $display("FAIL coll_event got=%h want rel=18 valid=1 id=4 coll=1", obs);
        end
      end
      if (e == 17) begin
        tests++;
        if (bus.release_pulse !== 5'b0 || bus.cmd_valid !== 1'b0 || bus.cmd_id !== 3'd0 || bus.cmd_collision !== 1'b0) begin
          fails++; $display("FAIL coll_after got=%h want pulses/cmd=0", obs);
        end
      end
      if (e == 10) bus.sw_in = '0;
    end
  endtask

  task automatic test_reset_mid;
    bus.sw_in = 5'b00010;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL mid_model got=%h want=%h", obs, exp_v); end
    end
    #5 rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 20'h0) begin fails++; $display("FAIL mid_async got=%h want=0", obs); end
    bus.sw_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== 20'h0 || obs !== exp_v) begin fails++; $display("FAIL mid_after edge=%0d got=%h want=0", e, obs); end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL random cycle=%0d in=%h got=%h want=%h", c, bus.sw_in, obs, exp_v); end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) bus.sw_in[i] = ~bus.sw_in[i];
    end
  endtask

  initial begin
    bus.sw_in = '0;
    test_reset();
    test_press_release();
    test_glitch();
    test_bounce();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
